aes_key_sched_ctrl: RTL and testbench

Sequencing controller for the AES-256 key schedule. Accepts a 256-bit cipher key over a valid/ready handshake. Drives the combinational single-step key-expansion datapath (256-bit key in, step index in, next 256-bit key out) once per cycle for 7 steps, and captures the 15 128-bit round keys into an internal register file. Serves those round keys to the cipher round engine through a registered read port, and sits between the key-load interface and the round engine.

---
 rtl/aes_key_sched_ctrl.sv | 161 ++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-256 key schedule sequencer.
// Accepts a 256-bit key over valid/ready. It steps an external combinational
// expansion datapath seven times, and captures the 15 round keys into a local
// register file. It also serves those round keys through a 1-cycle registered
// read port.
// Ports:
//   clk_i, reset_n_i        clock, async active-low reset
//   key_i/key_v_i/key_ready_o   key load handshake
//   step_key_o/step_r_o     key and step index presented to the datapath
//   step_result_i           datapath next-key result (same cycle)
//   rk_v_i/rk_idx_i         round-key read request
//   rk_o/rk_v_o/rk_err_o    round-key read response (1-cycle latency)
//   busy_o/done_o           expansion in progress / all round keys valid pulse
//   zeroize_i               synchronous wipe of all key material
module aes_key_sched_ctrl #(
  parameter int unsigned num_rounds_p = 14,
  parameter int unsigned steps_p      = 7
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [255:0] key_i,
  input  logic         key_v_i,
  output logic         key_ready_o,
  output logic [255:0] step_key_o,
  output logic [3:0]   step_r_o,
  input  logic [255:0] step_result_i,
  input  logic         rk_v_i,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_o,
  output logic         rk_v_o,
  output logic         rk_err_o,
  output logic         busy_o,
  output logic         done_o,
  input  logic         zeroize_i
);

  localparam int unsigned KEY_W  = 256;
  localparam int unsigned RK_W   = 128;
  localparam int unsigned NUM_RK = num_rounds_p + 1;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned WR_W   = STEP_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   s_q, s_d;
  logic [KEY_W-1:0]    work_q, work_d;
  logic                done_d;
  logic                key_acc;
  logic                step_wr;
  logic [RK_W-1:0]     rk_q [NUM_RK];
  logic [WR_W-1:0]     wr_lo_idx;
  logic [WR_W-1:0]     wr_hi_idx;
  logic                idx_oob;

  // Step s writes entries 2s and 2s+1; on the last step 2s+1 falls past the
  // end of the file, so the upper half is simply never matched.
  assign wr_lo_idx = {s_q, 1'b0};
  assign wr_hi_idx = {s_q, 1'b1};
  assign idx_oob   = (rk_idx_i > STEP_W'(num_rounds_p));

  assign step_key_o = work_q;
  assign step_r_o   = s_q;

  // Next-state, step counter and working-key logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    work_d  = work_q;
    done_d  = 1'b0;
    key_acc = 1'b0;
    step_wr = 1'b0;
    if (zeroize_i) begin
      state_d = IDLE;
      s_d     = '0;
      work_d  = '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (key_v_i) begin
            key_acc = 1'b1;
            state_d = EXPAND;
            s_d     = STEP_W'(1);
            work_d  = key_i;
          end
        end
        EXPAND: begin
          step_wr = 1'b1;
          work_d  = step_result_i;
          if (s_q == STEP_W'(steps_p)) begin
            state_d = READY;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + STEP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and handshake/status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      s_q         <= '0;
      work_q      <= '0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      key_ready_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      work_q      <= work_d;
      done_o      <= done_d;
      busy_o      <= (state_d == EXPAND);
      key_ready_o <= (state_d != EXPAND);
    end
  end

  // Round-key register file.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(NUM_RK); i++) rk_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_RK); i++) begin
        if (zeroize_i) begin
          rk_q[i] <= '0;
        end else if (key_acc) begin
          if (i == 0)      rk_q[i] <= key_i[RK_W-1:0];
          else if (i == 1) rk_q[i] <= key_i[KEY_W-1:RK_W];
        end else if (step_wr) begin
          if (wr_lo_idx == WR_W'(i))      rk_q[i] <= step_result_i[RK_W-1:0];
          else if (wr_hi_idx == WR_W'(i)) rk_q[i] <= step_result_i[KEY_W-1:RK_W];
        end
      end
    end
  end

  // Read port: reads the pre-edge contents, so a same-cycle write returns old data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rk_v_o   <= 1'b0;
      rk_err_o <= 1'b0;
      rk_o     <= '0;
    end else begin
      rk_v_o   <= rk_v_i;
      rk_err_o <= rk_v_i & idx_oob;
      if (rk_v_i && !idx_oob && !zeroize_i && (state_q != IDLE))
        rk_o <= rk_q[rk_idx_i];
      else
        rk_o <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with a behavioural AES-256
// expansion datapath and a full FIPS-197 key-expansion reference model.
module tb_aes_key_sched_ctrl;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [255:0] key_i;
  logic         key_v_i;
  logic         key_ready_o;
  logic [255:0] step_key_o;
  logic [3:0]   step_r_o;
  logic [255:0] step_result_i;
  logic         rk_v_i;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_o;
  logic         rk_v_o;
  logic         rk_err_o;
  logic         busy_o;
  logic         done_o;
  logic         zeroize_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mw [60];

  aes_key_sched_ctrl dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .key_i(key_i), .key_v_i(key_v_i), .key_ready_o(key_ready_o),
    .step_key_o(step_key_o), .step_r_o(step_r_o), .step_result_i(step_result_i),
    .rk_v_i(rk_v_i), .rk_idx_i(rk_idx_i),
    .rk_o(rk_o), .rk_v_o(rk_v_o), .rk_err_o(rk_err_o),
    .busy_o(busy_o), .done_o(done_o), .zeroize_i(zeroize_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input int j);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < j; k++) r = xtime(r);
    return {r, 24'h0};
  endfunction

  // Golden single-step datapath: 8 words in, next 8 words out for step s.
  function automatic logic [255:0] dp_step(input logic [255:0] k, input logic [3:0] s);
    logic [31:0]  w [16];
    logic [31:0]  t;
    logic [255:0] r;
    for (int j = 0; j < 8; j++) w[j] = k[32*j +: 32];
    for (int j = 8; j < 16; j++) begin
      t = w[j-1];
      if (j == 8)       t = sub_word(rot_word(t)) ^ rcon(int'(s));
      else if (j == 12) t = sub_word(t);
      w[j] = w[j-8] ^ t;
    end
    for (int j = 0; j < 8; j++) r[32*j +: 32] = w[8+j];
    return r;
  endfunction

  assign step_result_i = dp_step(step_key_o, step_r_o);

  // Reference model: the whole 60-word FIPS-197 schedule.
  task automatic model_expand(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) mw[i] = k[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = mw[i-1];
      if (i % 8 == 0)      t = sub_word(rot_word(t)) ^ rcon(i / 8);
      else if (i % 8 == 4) t = sub_word(t);
      mw[i] = mw[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int n);
    return {mw[4*n+3], mw[4*n+2], mw[4*n+1], mw[4*n]};
  endfunction

  function automatic logic [255:0] model_key(input int k);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = mw[8*k+j];
    return r;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 256'(key_ready_o), 256'd1);
    check({tag, "_busy"},      256'(busy_o),      256'd0);
    check({tag, "_done"},      256'(done_o),      256'd0);
    check({tag, "_rk_v"},      256'(rk_v_o),      256'd0);
    check({tag, "_rk_err"},    256'(rk_err_o),    256'd0);
    check({tag, "_rk"},        256'(rk_o),        256'd0);
    check({tag, "_step_key"},  step_key_o,        256'd0);
    check({tag, "_step_r"},    256'(step_r_o),    256'd0);
  endtask

  task automatic read_one(input string tag, input int idx, input logic [127:0] expv);
    rk_v_i   = 1'b1;
    rk_idx_i = 4'(idx);
    tick();
    rk_v_i = 1'b0;
    check({tag, "_v"},   256'(rk_v_o),   256'd1);
    check({tag, "_err"}, 256'(rk_err_o), 256'd0);
    check({tag, "_rk"},  256'(rk_o),     256'(expv));
  endtask

  // Back-to-back reads of 0..15; zero_exp selects all-zero expectations.
  task automatic read_all(input string tag, input bit zero_exp);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) begin
      rk_v_i   = 1'b1;
      rk_idx_i = 4'(i);
      tick();
      e = (i < 15 && !zero_exp) ? model_rk(i) : 128'd0;
      check($sformatf("%s_v%0d", tag, i),   256'(rk_v_o),   256'd1);
      check($sformatf("%s_err%0d", tag, i), 256'(rk_err_o), 256'(i == 15));
      check($sformatf("%s_rk%0d", tag, i),  256'(rk_o),     256'(e));
    end
    rk_v_i = 1'b0;
    tick();
    check({tag, "_v_idle"}, 256'(rk_v_o), 256'd0);
  endtask

  // Called in cycle E0+1; returns in the done cycle (or at the cycle bound).
  task automatic wait_done(input string tag);
    int lat = 1;
    while (!done_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 256'(lat), 256'd8);
  endtask

  initial begin
    logic [255:0] kf, ka, kb;
    reset_n_i = 1'b0;
    key_i     = '0;
    key_v_i   = 1'b0;
    rk_v_i    = 1'b0;
    rk_idx_i  = '0;
    zeroize_i = 1'b0;

    // Reset values.
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n_i = 1'b1;
    tick();

    // FIPS-197 key with a different key held valid throughout EXPAND.
    for (int j = 0; j < 8; j++)
      kf[32*j +: 32] = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
    model_expand(kf);
    key_i   = kf;
    key_v_i = 1'b1;
    check("fips_ready_before", 256'(key_ready_o), 256'd1);
    tick();
    key_i = rand_key();
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("seq_step_r%0d", k),    256'(step_r_o),    256'(k));
      check($sformatf("seq_busy%0d", k),      256'(busy_o),      256'd1);
      check($sformatf("seq_key_ready%0d", k), 256'(key_ready_o), 256'd0);
      check($sformatf("seq_done%0d", k),      256'(done_o),      256'd0);
      check($sformatf("seq_step_key%0d", k),  step_key_o,        model_key(k-1));
      if (k == 7) key_v_i = 1'b0;
      tick();
    end
    check("seq_step_r_end", 256'(step_r_o),    256'd0);
    check("seq_done_end",   256'(done_o),      256'd1);
    check("seq_busy_end",   256'(busy_o),      256'd0);
    check("seq_ready_end",  256'(key_ready_o), 256'd1);
    tick();
    check("seq_done_pulse", 256'(done_o), 256'd0);

    read_one("fips_rk1",  1,  128'h1c1d1e1f_18191a1b_14151617_10111213);
    read_one("fips_rk2",  2,  128'ha572c09c_a97fce93_a176c498_a573c29f);
    read_one("fips_rk14", 14, 128'h6d68de36_371ac23c_bf0979e9_24fc79cc);
    read_all("fips_all", 1'b0);

    // Rekey in the done cycle: key A then key B with no gap.
    ka = rand_key();
    kb = rand_key();
    key_i   = ka;
    key_v_i = 1'b1;
    tick();
    key_v_i = 1'b0;
    wait_done("rekey_a");
    key_i   = kb;
    key_v_i = 1'b1;
    check("rekey_ready_at_done", 256'(key_ready_o), 256'd1);
    tick();
    key_v_i = 1'b0;
    check("rekey_b_busy",     256'(busy_o),   256'd1);
    check("rekey_b_step_r",   256'(step_r_o), 256'd1);
    check("rekey_b_step_key", step_key_o,     kb);
    wait_done("rekey_b");
    tick();
    model_expand(kb);
    read_one("rekey_b_rk14", 14, model_rk(14));
    read_all("rekey_b_all", 1'b0);

    // Zeroize with a simultaneous key offer and read.
    zeroize_i = 1'b1;
    key_i     = rand_key();
    key_v_i   = 1'b1;
    rk_v_i    = 1'b1;
    rk_idx_i  = 4'd3;
    tick();
    zeroize_i = 1'b0;
    key_v_i   = 1'b0;
    rk_v_i    = 1'b0;
    check("zero_rk_v",      256'(rk_v_o),      256'd1);
    check("zero_rk",        256'(rk_o),        256'd0);
    check("zero_key_ready", 256'(key_ready_o), 256'd1);
    check("zero_busy",      256'(busy_o),      256'd0);
    check("zero_step_key",  step_key_o,        256'd0);
    tick();
    check("zero_busy_after", 256'(busy_o), 256'd0);
    read_all("zero_all", 1'b1);

    // Reset at E0+3 of an expansion.
    key_i   = rand_key();
    key_v_i = 1'b1;
    tick();
    key_v_i = 1'b0;
    tick();
    tick();
    check("rst_mid_step_r", 256'(step_r_o), 256'd3);
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    reset_n_i = 1'b1;
    tick();
    read_one("rst_mid_rk5", 5, 128'd0);
    read_all("rst_mid_all", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
